// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the fetch/data memory arbiter: data-path width,
// arbiter state encoding, last-grant encoding and the fetch address
// alignment helper.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DATA   = 2'd2,
      ST_HALTED = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   // Instruction fetches are halfword aligned: bit 0 of the fetch address
   // never reaches the memory port.
   function automatic logic [DATA_W-1:0] fetch_align(input logic [DATA_W-1:0] addr);
      return addr & {{(DATA_W-1){1'b1}}, 1'b0};
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
// Combinational two-requester pick between the data port and the fetch port.
// Data normally wins; when the previous grant went to data and a fetch is
// waiting, the fetch wins so the instruction stream cannot be starved.
//
// Ports
//   req_d     in   data request (already masked by the caller)
//   req_f     in   fetch request (already masked by the caller)
//   last_data in   previous grant went to the data port
//   gnt_d     out  grant data
//   gnt_f     out  grant fetch
// ---------------------------------------------------------------------------
module arb_pick2 (
   input  logic req_d,
   input  logic req_f,
   input  logic last_data,
   output logic gnt_d,
   output logic gnt_f
);

   assign gnt_f = req_f & (~req_d | last_data);
   assign gnt_d = req_d & ~gnt_f;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-outstanding memory port between an instruction fetch
// requester and a data load/store requester. One access is in flight at a
// time; completion is signalled by mem_done and turned into a registered
// one-cycle valid pulse with registered read data. A decoded halt parks the
// arbiter until reset.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   if_req, if_addr       fetch request (held until if_valid) and address
//   d_rd, d_wr            data read / write request (held until d_valid)
//   d_addr, d_wdata       data address and store data
//   halt                  halt decoded (level)
//   mem_req, mem_wr       memory strobe and write enable
//   mem_addr, mem_wdata   memory address and write data
//   mem_done, mem_rdata   memory completion pulse and read data
//   if_valid, if_data     fetch completion pulse and fetched word
//   d_valid, d_rdata      data completion pulse and load data
//   stall                 combinational pipeline stall
//   err                   pulse on misaligned or rd+wr data access
//   halted                arbiter parked
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [DATA_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              halt,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_data,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall,
   output logic              err,
   output logic              halted
);

   arb_state_t state;
   grant_t     last_grant;
   logic       pair_err;   // in-flight data access was issued with rd and wr both high
   logic       req_d;
   logic       req_f;
   logic       gnt_d;
   logic       gnt_f;

   // A requester whose valid is pulsing this cycle is still holding its old
   // request; mask it so the same access is not issued twice. Halt removes
   // fetches from arbitration entirely.
   assign req_d = (d_rd | d_wr) & ~d_valid;
   assign req_f = if_req & ~if_valid & ~halt;

   arb_pick2 u_pick (
      .req_d     (req_d),
      .req_f     (req_f),
      .last_data (last_grant == GNT_DATA),
      .gnt_d     (gnt_d),
      .gnt_f     (gnt_f)
   );

   assign stall = (if_req & ~if_valid) | ((d_rd | d_wr) & ~d_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= GNT_FETCH;
         pair_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_valid   <= 1'b0;
         if_data    <= '0;
         d_valid    <= 1'b0;
         d_rdata    <= '0;
         err        <= 1'b0;
         halted     <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               // mem_done here belongs to nobody (stale or spurious) and is dropped.
               if (gnt_d) begin
                  last_grant <= GNT_DATA;
                  if (d_addr[0]) begin
                     // Misaligned: answer immediately without touching memory.
                     d_valid <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     state     <= ST_DATA;
                     mem_req   <= 1'b1;
                     mem_wr    <= d_wr;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     pair_err  <= d_rd & d_wr;
                  end
               end else if (gnt_f) begin
                  last_grant <= GNT_FETCH;
                  state      <= ST_FETCH;
                  mem_req    <= 1'b1;
                  mem_wr     <= 1'b0;
                  mem_addr   <= fetch_align(if_addr);
               end else if (halt) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (mem_done) begin
                  state    <= ST_IDLE;
                  mem_req  <= 1'b0;
                  if_valid <= 1'b1;
                  if_data  <= mem_rdata;
               end
            end
            ST_DATA: begin
               if (mem_done) begin
                  state   <= ST_IDLE;
                  mem_req <= 1'b0;
                  mem_wr  <= 1'b0;
                  d_valid <= 1'b1;
                  err     <= pair_err;
                  if (!mem_wr) d_rdata <= mem_rdata;
               end
            end
            default: begin
               // Parked: everything is ignored until reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory responder, all checked
// every cycle against a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        d_rd = 1'b0, d_wr = 1'b0;
   logic [15:0] d_addr = '0, d_wdata = '0;
   logic        halt = 1'b0;
   logic        mem_req, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        if_valid, d_valid, stall, err, halted;
   logic [15:0] if_data, d_rdata;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .halt(halt), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .if_valid(if_valid), .if_data(if_data), .d_valid(d_valid),
      .d_rdata(d_rdata), .stall(stall), .err(err), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: who owns the memory port, whether the arbiter is
   // parked, and a log of past grants ("F"/"D") for the fairness rule.
   // ------------------------------------------------------------------
   byte         m_owner = "N";
   bit          m_parked = 0;
   bit          m_pair = 0;
   byte         grant_log[$];
   logic        e_mem_req = 0, e_mem_wr = 0, e_if_valid = 0, e_d_valid = 0;
   logic        e_err = 0, e_halted = 0;
   logic [15:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_data = '0, e_d_rdata = '0;

   always @(posedge clk or posedge rst) begin
      bit nv_if, nv_d, n_err, last_d, want_d, want_f;
      nv_if = 0; nv_d = 0; n_err = 0;
      if (rst) begin
         m_owner = "N"; m_parked = 0; m_pair = 0; grant_log.delete();
         e_mem_wr = 0; e_mem_addr = '0; e_mem_wdata = '0;
         e_if_data = '0; e_d_rdata = '0;
      end else if (m_parked) begin
         // parked until reset
      end else if (m_owner != "N") begin
         if (mem_done) begin
            if (m_owner == "F") begin
               nv_if = 1; e_if_data = mem_rdata;
            end else begin
               nv_d = 1; n_err = m_pair;
               if (!e_mem_wr) e_d_rdata = mem_rdata;
            end
            e_mem_wr = 0;
            m_owner  = "N";
         end
      end else begin
         last_d = (grant_log.size() > 0) && (grant_log[$] == "D");
         want_d = (d_rd || d_wr) && !e_d_valid;
         want_f = if_req && !e_if_valid && !halt;
         if (want_f && (!want_d || last_d)) begin
            grant_log.push_back("F");
            m_owner = "F"; e_mem_wr = 0; e_mem_addr = {if_addr[15:1], 1'b0};
         end else if (want_d) begin
            grant_log.push_back("D");
            if (d_addr[0]) begin
               nv_d = 1; n_err = 1;
            end else begin
               m_owner = "D"; e_mem_wr = d_wr; e_mem_addr = d_addr;
               e_mem_wdata = d_wdata; m_pair = d_rd && d_wr;
            end
         end else if (halt) begin
            m_parked = 1;
         end
         if (grant_log.size() > 8) void'(grant_log.pop_front());
      end
      e_if_valid = nv_if; e_d_valid = nv_d; e_err = n_err;
      e_halted = m_parked; e_mem_req = (m_owner != "N");
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("if_valid", if_valid, e_if_valid);
         chk("d_valid", d_valid, e_d_valid);
         chk("err", err, e_err);
         chk("halted", halted, e_halted);
         chk("mem_req", mem_req, e_mem_req);
         chk("mem_wr", mem_wr, e_mem_wr);
         chk("mem_addr", mem_addr, e_mem_addr);
         if (e_mem_wr) chk("mem_wdata", mem_wdata, e_mem_wdata);
         chk("if_data", if_data, e_if_data);
         chk("d_rdata", d_rdata, e_d_rdata);
         chk("stall", stall, (if_req & ~e_if_valid) | ((d_rd | d_wr) & ~e_d_valid));
      end
   end

   // ------------------------------------------------------------------
   // Memory responder: fixed latency, random latency, or manual.
   // ------------------------------------------------------------------
   bit          rsp_en = 1, rsp_rand = 0, man_done = 0;
   int          rsp_lat = 1, rsp_cnt = 0;
   logic [15:0] rsp_data = '0;

   always @(negedge clk) begin
      #1;
      if (!rsp_en) begin
         mem_done = man_done; mem_rdata = rsp_data;
      end else if (mem_done) begin
         mem_done = 0; rsp_cnt = 0;
      end else if (mem_req) begin
         if (rsp_rand ? ($urandom_range(0, 1) == 0) : (rsp_cnt >= rsp_lat)) begin
            mem_done = 1; mem_rdata = rsp_rand ? 16'($urandom) : rsp_data;
         end else rsp_cnt++;
      end else begin
         rsp_cnt = 0;
         if (rsp_rand && $urandom_range(0, 7) == 0) begin
            mem_done = 1; mem_rdata = 16'($urandom);
         end
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_mem_req(input string name);
      for (int i = 0; i < 12 && !mem_req; i++) tick;
      chk(name, mem_req, 1'b1);
   endtask

   int          npulse;
   logic [31:0] order;
   int          park_cnt;

   initial begin
      rst = 1'b1;
      repeat (3) tick;
      // Reset state
      chk("rst mem_req", mem_req, 0);   chk("rst mem_wr", mem_wr, 0);
      chk("rst if_valid", if_valid, 0); chk("rst d_valid", d_valid, 0);
      chk("rst err", err, 0);           chk("rst halted", halted, 0);
      chk("rst mem_addr", mem_addr, 0); chk("rst mem_wdata", mem_wdata, 0);
      chk("rst if_data", if_data, 0);   chk("rst d_rdata", d_rdata, 0);
      rst = 1'b0;
      cmp_on = 1;
      tick;

      // Fetch only, memory answers 2 cycles after mem_req rises
      rsp_lat = 2; rsp_data = 16'hA5A5;
      if_req = 1; if_addr = 16'h0010;
      wait_mem_req("fetch mem_req");
      chk("fetch mem_addr", mem_addr, 16'h0010);
      chk("fetch stall", stall, 1);
      for (int i = 0; i < 12 && !if_valid; i++) tick;
      chk("fetch if_valid", if_valid, 1);
      chk("fetch if_data", if_data, 16'hA5A5);
      chk("fetch stall at valid", stall, 0);
      if_req = 0;
      tick;
      chk("fetch single pulse", if_valid, 0);
      chk("fetch stall after", stall, 0);
      repeat (2) tick;

      // Contention: data and fetch held continuously, grants alternate
      rsp_lat = 1; rsp_data = 16'h5A5A;
      if_req = 1; if_addr = 16'h0040; d_rd = 1; d_addr = 16'h0200;
      npulse = 0; order = '0;
      for (int i = 0; i < 60 && npulse < 4; i++) begin
         tick;
         if (d_valid)  begin order = {order[23:0], 8'h44}; npulse++; end
         if (if_valid) begin order = {order[23:0], 8'h46}; npulse++; end
      end
      if_req = 0; d_rd = 0;
      chk("contend order DFDF", order, 32'h44464446);
      chk("contend load data", d_rdata, 16'h5A5A);
      repeat (3) tick;

      // Store leaves load data untouched
      rsp_data = 16'hFFFF;
      d_wr = 1; d_addr = 16'h0004; d_wdata = 16'h1234;
      wait_mem_req("store mem_req");
      chk("store mem_wr", mem_wr, 1);
      chk("store mem_wdata", mem_wdata, 16'h1234);
      chk("store mem_addr", mem_addr, 16'h0004);
      for (int i = 0; i < 12 && !d_valid; i++) tick;
      chk("store d_valid", d_valid, 1);
      chk("store d_rdata kept", d_rdata, 16'h5A5A);
      chk("store err", err, 0);
      d_wr = 0;
      repeat (2) tick;

      // Misaligned load: immediate error, no memory access
      d_rd = 1; d_addr = 16'h0003;
      tick;
      chk("misal err", err, 1);
      chk("misal d_valid", d_valid, 1);
      chk("misal mem_req", mem_req, 0);
      d_rd = 0;
      tick;
      chk("misal mem_req after", mem_req, 0);
      chk("misal err single", err, 0);
      repeat (2) tick;

      // Reset in the middle of a data access, then a late mem_done
      rsp_en = 0; man_done = 0; rsp_data = 16'hBEEF;
      d_rd = 1; d_addr = 16'h0100;
      wait_mem_req("rstmid mem_req");
      rst = 1; d_rd = 0;
      tick;
      chk("rstmid mem_req", mem_req, 0);
      chk("rstmid mem_addr", mem_addr, 0);
      chk("rstmid d_rdata", d_rdata, 0);
      rst = 0;
      tick;
      man_done = 1;
      tick;
      man_done = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("late done d_valid", d_valid, 0);
         chk("late done mem_req", mem_req, 0);
         chk("late done d_rdata", d_rdata, 0);
      end
      rsp_en = 1;

      // Halt during a fetch: fetch completes, then parked for good
      rsp_lat = 2; rsp_data = 16'h0F0F;
      if_req = 1; if_addr = 16'h0081;
      wait_mem_req("halt mem_req");
      chk("halt fetch aligned", mem_addr, 16'h0080);
      halt = 1;
      for (int i = 0; i < 12 && !if_valid; i++) tick;
      chk("halt fetch completes", if_valid, 1);
      chk("halt fetch data", if_data, 16'h0F0F);
      tick;
      chk("halted set", halted, 1);
      halt = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("halted no mem_req", mem_req, 0);
         chk("halted held", halted, 1);
      end
      rst = 1; if_req = 0;
      tick;
      chk("unhalt by rst", halted, 0);
      rst = 0;
      tick;

      // Randomized traffic
      rsp_rand = 1; park_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         tick;
         if (rst) rst = 0;
         else if (halted) begin
            park_cnt++;
            if (park_cnt > 4) begin rst = 1; halt = 0; park_cnt = 0; end
         end else if ($urandom_range(0, 499) == 0) rst = 1;
         if (!halt && $urandom_range(0, 299) == 0) halt = 1;
         if (if_req) begin
            if (if_valid) begin if_req = $urandom_range(0, 1) == 1; if_addr = 16'($urandom); end
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = 16'($urandom);
         end
         if (d_rd || d_wr) begin
            if (d_valid) begin d_rd = 0; d_wr = 0; end
         end
         if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
               0, 1, 2, 3: d_rd = 1;
               4, 5, 6:    d_wr = 1;
               default:    begin d_rd = 1; d_wr = 1; end
            endcase
            d_addr  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 5) == 0) d_addr[0] = 1'b1;
            d_wdata = 16'($urandom);
         end
      end
      rsp_rand = 0;
      if_req = 0; d_rd = 0; d_wr = 0; halt = 0; rst = 0;
      repeat (5) tick;
      cmp_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
